// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU ops until both operands
// are resolved, snoops result broadcasts, issues one ready op per cycle.
module alu_reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [4:0]       op_in,
  input  logic [31:0]      value1_in,
  input  logic [31:0]      value2_in,
  input  logic [TAG_W-1:0] query1_in,
  input  logic [TAG_W-1:0] query2_in,
  input  logic [31:0]      imm_in,
  input  logic [TAG_W-1:0] target_in,
  input  logic             is_branch_in,
  input  logic [TAG_W-1:0] alu_num,
  input  logic [31:0]      alu_value,
  input  logic [TAG_W-1:0] mem_num,
  input  logic [31:0]      mem_value,
  output logic             rs_full,
  output logic             issue_valid,
  output logic [4:0]       issue_op,
  output logic [31:0]      issue_a,
  output logic [31:0]      issue_b,
  output logic [31:0]      issue_imm,
  output logic [TAG_W-1:0] issue_dest,
  output logic             issue_is_branch
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [4:0] OP_NONE = 5'b11111;
  localparam logic [4:0] OP_LB   = 5'b10010;
  localparam logic [4:0] OP_SW   = 5'b11001;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][4:0]        op_q, op_d;
  logic [DEPTH-1:0][31:0]       v1_q, v1_d;
  logic [DEPTH-1:0][31:0]       v2_q, v2_d;
  logic [DEPTH-1:0][TAG_W-1:0]  q1_q, q1_d;
  logic [DEPTH-1:0][TAG_W-1:0]  q2_q, q2_d;
  logic [DEPTH-1:0][31:0]       imm_q, imm_d;
  logic [DEPTH-1:0][TAG_W-1:0]  dest_q, dest_d;
  logic [DEPTH-1:0]             br_q, br_d;

  logic             full_q, full_d;
  logic             iv_q, iv_d;
  logic [4:0]       iop_q, iop_d;
  logic [31:0]      ia_q, ia_d;
  logic [31:0]      ib_q, ib_d;
  logic [31:0]      iimm_q, iimm_d;
  logic [TAG_W-1:0] idest_q, idest_d;
  logic             ibr_q, ibr_d;

  logic [DEPTH-1:0] ready;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic             accept;
  logic             has_free;
  logic [IDX_W-1:0] free_idx;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] dq1, dq2;
  logic [31:0]      dv1, dv2;
  logic [TAG_W-1:0] wq1, wq2;
  logic [31:0]      wv1, wv2;

  // ALU broadcast wins over memory if both tags match.
  function automatic void wake(
    input  logic [TAG_W-1:0] q_i,
    input  logic [31:0]      v_i,
    input  logic [TAG_W-1:0] an,
    input  logic [31:0]      av,
    input  logic [TAG_W-1:0] mn,
    input  logic [31:0]      mv,
    output logic [TAG_W-1:0] q_o,
    output logic [31:0]      v_o
  );
    q_o = q_i;
    v_o = v_i;
    if (q_i != '0 && q_i == an) begin
      q_o = '0;
      v_o = av;
    end else if (q_i != '0 && q_i == mn) begin
      q_o = '0;
      v_o = mv;
    end
  endfunction

  assign accept = (op_in != OP_NONE) &&
                  !((op_in >= OP_LB) && (op_in <= OP_SW));

  always_comb begin
    ready = '0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && ready[i]) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    q1_d     = q1_q;
    q2_d     = q2_q;
    imm_d    = imm_q;
    dest_d   = dest_q;
    br_d     = br_q;
    has_free = 1'b0;
    free_idx = '0;
    cnt      = '0;
    dq1      = '0;
    dq2      = '0;
    dv1      = '0;
    dv2      = '0;
    wq1      = '0;
    wq2      = '0;
    wv1      = '0;
    wv2      = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        wake(q1_q[i], v1_q[i], alu_num, alu_value,
             mem_num, mem_value, wq1, wv1);
        wake(q2_q[i], v2_q[i], alu_num, alu_value,
             mem_num, mem_value, wq2, wv2);
        q1_d[i] = wq1;
        v1_d[i] = wv1;
        q2_d[i] = wq2;
        v2_d[i] = wv2;
      end
    end

    if (found) begin
      valid_d[sel] = 1'b0;
    end

    // Free slot search runs after issue removal so a slot can be reused.
    for (int i = 0; i < DEPTH; i++) begin
      if (!has_free && !valid_d[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end

    wake(query1_in, value1_in, alu_num, alu_value,
         mem_num, mem_value, dq1, dv1);
    wake(query2_in, value2_in, alu_num, alu_value,
         mem_num, mem_value, dq2, dv2);

    if (accept && has_free) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = op_in;
      v1_d[free_idx]    = dv1;
      q1_d[free_idx]    = dq1;
      v2_d[free_idx]    = dv2;
      q2_d[free_idx]    = dq2;
      imm_d[free_idx]   = imm_in;
      dest_d[free_idx]  = target_in;
      br_d[free_idx]    = is_branch_in;
    end

    if (flush) begin
      valid_d = '0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CNT_W'(valid_d[i]);
    end
    full_d = (cnt >= CNT_W'(DEPTH - 1));
  end

  always_comb begin
    iv_d    = 1'b0;
    iop_d   = OP_NONE;
    ia_d    = '0;
    ib_d    = '0;
    iimm_d  = '0;
    idest_d = '0;
    ibr_d   = 1'b0;
    if (found && !flush) begin
      iv_d    = 1'b1;
      iop_d   = op_q[sel];
      ia_d    = v1_q[sel];
      ib_d    = v2_q[sel];
      iimm_d  = imm_q[sel];
      idest_d = dest_q[sel];
      ibr_d   = br_q[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      op_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
      imm_q   <= '0;
      dest_q  <= '0;
      br_q    <= '0;
      full_q  <= 1'b0;
      iv_q    <= 1'b0;
      iop_q   <= OP_NONE;
      ia_q    <= '0;
      ib_q    <= '0;
      iimm_q  <= '0;
      idest_q <= '0;
      ibr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      imm_q   <= imm_d;
      dest_q  <= dest_d;
      br_q    <= br_d;
      full_q  <= full_d;
      iv_q    <= iv_d;
      iop_q   <= iop_d;
      ia_q    <= ia_d;
      ib_q    <= ib_d;
      iimm_q  <= iimm_d;
      idest_q <= idest_d;
      ibr_q   <= ibr_d;
    end
  end

  assign rs_full         = full_q;
  assign issue_valid     = iv_q;
  assign issue_op        = iop_q;
  assign issue_a         = ia_q;
  assign issue_b         = ib_q;
  assign issue_imm       = iimm_q;
  assign issue_dest      = idest_q;
  assign issue_is_branch = ibr_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed testbench for alu_reservation_station.
// Inputs change 1ns after posedge; outputs are checked at that point too.
module tb_alu_reservation_station;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [4:0]  op_in;
  logic [31:0] value1_in, value2_in, imm_in;
  logic [2:0]  query1_in, query2_in, target_in;
  logic        is_branch_in;
  logic [2:0]  alu_num, mem_num;
  logic [31:0] alu_value, mem_value;
  logic        rs_full, issue_valid, issue_is_branch;
  logic [4:0]  issue_op;
  logic [31:0] issue_a, issue_b, issue_imm;
  logic [2:0]  issue_dest;

  int checks;
  int errors;

  alu_reservation_station #(.DEPTH(4), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .op_in(op_in), .value1_in(value1_in), .value2_in(value2_in),
    .query1_in(query1_in), .query2_in(query2_in), .imm_in(imm_in),
    .target_in(target_in), .is_branch_in(is_branch_in),
    .alu_num(alu_num), .alu_value(alu_value),
    .mem_num(mem_num), .mem_value(mem_value),
    .rs_full(rs_full), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_imm(issue_imm),
    .issue_dest(issue_dest), .issue_is_branch(issue_is_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    op_in = 5'b11111;
    value1_in = '0;
    value2_in = '0;
    query1_in = '0;
    query2_in = '0;
    imm_in = '0;
    target_in = '0;
    is_branch_in = 1'b0;
    alu_num = '0;
    alu_value = '0;
    mem_num = '0;
    mem_value = '0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] v1,
                      input logic [2:0] q1, input logic [31:0] v2,
                      input logic [2:0] q2, input logic [2:0] tgt);
    op_in = op;
    value1_in = v1;
    query1_in = q1;
    value2_in = v2;
    query2_in = q2;
    target_in = tgt;
    imm_in = 32'h1000 + 32'(tgt);
    is_branch_in = tgt[0];
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", issue_valid);
    end
    checks++;
    if (issue_op !== 5'b11111 || issue_dest !== 3'd0) begin
      errors++;
      $display("FAIL reset_op_dest: got op=%b dest=%0d expected 11111/0",
               issue_op, issue_dest);
    end
    checks++;
    if (issue_a !== 0 || issue_b !== 0 || issue_imm !== 0 ||
        issue_is_branch !== 1'b0 || rs_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_fields: a=%h b=%h imm=%h br=%b full=%b",
               issue_a, issue_b, issue_imm, issue_is_branch, rs_full);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_ready_issue();
    disp(5'd0, 32'd5, 3'd0, 32'd7, 3'd0, 3'd2);
    step();
    idle();
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_latency: got valid=%b expected 0", issue_valid);
    end
    step();
    checks++;
    if (issue_valid !== 1'b1 || issue_op !== 5'd0 || issue_a !== 32'd5 ||
        issue_b !== 32'd7 || issue_dest !== 3'd2) begin
      errors++;
      $display("FAIL add_issue: v=%b op=%0d a=%0d b=%0d d=%0d exp 1/0/5/7/2",
               issue_valid, issue_op, issue_a, issue_b, issue_dest);
    end
    checks++;
    if (issue_imm !== 32'h1002 || issue_is_branch !== 1'b0) begin
      errors++;
      $display("FAIL add_imm: imm=%h br=%b expected 1002/0",
               issue_imm, issue_is_branch);
    end
    step();
    checks++;
    if (issue_valid !== 1'b0 || issue_op !== 5'b11111) begin
      errors++;
      $display("FAIL add_idle: v=%b op=%b expected 0/11111",
               issue_valid, issue_op);
    end
  endtask

  task automatic test_alu_wakeup();
    disp(5'd1, 32'd0, 3'd1, 32'd9, 3'd0, 3'd3);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (issue_valid !== 1'b0) begin
        errors++;
        $display("FAIL sub_wait%0d: got valid=%b expected 0", i, issue_valid);
      end
    end
    alu_num = 3'd1;
    alu_value = 32'h10;
    step();
    idle();
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_wake_edge: got valid=%b expected 0", issue_valid);
    end
    step();
    checks++;
    if (issue_valid !== 1'b1 || issue_op !== 5'd1 || issue_a !== 32'h10 ||
        issue_b !== 32'd9 || issue_dest !== 3'd3 ||
        issue_is_branch !== 1'b1) begin
      errors++;
      $display("FAIL sub_issue: v=%b op=%0d a=%h b=%0d d=%0d br=%b",
               issue_valid, issue_op, issue_a, issue_b, issue_dest,
               issue_is_branch);
    end
    step();
  endtask

  task automatic test_dispatch_bypass();
    disp(5'd0, 32'd1, 3'd0, 32'd0, 3'd4, 3'd4);
    mem_num = 3'd4;
    mem_value = 32'hAB;
    step();
    idle();
    step();
    checks++;
    if (issue_valid !== 1'b1 || issue_a !== 32'd1 || issue_b !== 32'hAB ||
        issue_dest !== 3'd4) begin
      errors++;
      $display("FAIL bypass: v=%b a=%h b=%h d=%0d expected 1/1/ab/4",
               issue_valid, issue_a, issue_b, issue_dest);
    end
    step();
  endtask

  task automatic test_load_store_filter();
    disp(5'b10100, 32'd1, 3'd0, 32'd2, 3'd0, 3'd5);
    step();
    disp(5'b10010, 32'd1, 3'd0, 32'd2, 3'd0, 3'd6);
    step();
    disp(5'b11001, 32'd1, 3'd0, 32'd2, 3'd0, 3'd7);
    step();
    idle();
    step();
    checks++;
    if (issue_valid !== 1'b0 || rs_full !== 1'b0) begin
      errors++;
      $display("FAIL ldst_drop: v=%b full=%b expected 0/0",
               issue_valid, rs_full);
    end
    disp(5'b11010, 32'd3, 3'd0, 32'd4, 3'd0, 3'd5);
    step();
    idle();
    step();
    checks++;
    if (issue_valid !== 1'b1 || issue_op !== 5'b11010 ||
        issue_dest !== 3'd5) begin
      errors++;
      $display("FAIL above_sw: v=%b op=%b d=%0d expected 1/11010/5",
               issue_valid, issue_op, issue_dest);
    end
    step();
  endtask

  task automatic test_fill_and_drain();
    logic exp_full [4];
    exp_full = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      disp(5'(i + 1), 32'd0, 3'd5, 32'h100 + 32'(i), 3'd0, 3'(i + 1));
      step();
      checks++;
      if (rs_full !== exp_full[i] || issue_valid !== 1'b0) begin
        errors++;
        $display("FAIL fill%0d: full=%b v=%b expected %b/0",
                 i, rs_full, issue_valid, exp_full[i]);
      end
    end
    idle();
    alu_num = 3'd5;
    alu_value = 32'h55;
    step();
    idle();
    checks++;
    if (rs_full !== 1'b1 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_wake: full=%b v=%b expected 1/0",
               rs_full, issue_valid);
    end
    exp_full = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (issue_valid !== 1'b1 || issue_dest !== 3'(i + 1) ||
          issue_op !== 5'(i + 1) || issue_a !== 32'h55 ||
          issue_b !== 32'h100 + 32'(i) || rs_full !== exp_full[i]) begin
        errors++;
        $display("FAIL drain%0d: v=%b d=%0d op=%0d a=%h b=%h full=%b exp d=%0d full=%b",
                 i, issue_valid, issue_dest, issue_op, issue_a, issue_b,
                 rs_full, i + 1, exp_full[i]);
      end
    end
    step();
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: got valid=%b expected 0", issue_valid);
    end
  endtask

  task automatic test_back_to_back();
    disp(5'd2, 32'd11, 3'd0, 32'd12, 3'd0, 3'd1);
    step();
    disp(5'd3, 32'd21, 3'd0, 32'd22, 3'd0, 3'd2);
    step();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || issue_dest !== 3'd1) begin
      errors++;
      $display("FAIL b2b_first: v=%b d=%0d expected 1/1",
               issue_valid, issue_dest);
    end
    step();
    checks++;
    if (issue_valid !== 1'b1 || issue_dest !== 3'd2 || issue_a !== 32'd21) begin
      errors++;
      $display("FAIL b2b_second: v=%b d=%0d a=%0d expected 1/2/21",
               issue_valid, issue_dest, issue_a);
    end
    step();
  endtask

  task automatic test_flush();
    disp(5'd0, 32'd0, 3'd6, 32'd1, 3'd0, 3'd1);
    step();
    disp(5'd0, 32'd0, 3'd6, 32'd2, 3'd0, 3'd2);
    step();
    disp(5'd0, 32'd8, 3'd0, 32'd9, 3'd0, 3'd7);
    flush = 1'b1;
    step();
    idle();
    checks++;
    if (issue_valid !== 1'b0 || rs_full !== 1'b0 ||
        issue_op !== 5'b11111 || issue_dest !== 3'd0) begin
      errors++;
      $display("FAIL flush_now: v=%b full=%b op=%b d=%0d expected 0/0/11111/0",
               issue_valid, rs_full, issue_op, issue_dest);
    end
    step();
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got valid=%b expected 0", issue_valid);
    end
    alu_num = 3'd6;
    alu_value = 32'h66;
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (issue_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_wake%0d: got valid=%b expected 0", i, issue_valid);
      end
    end
    disp(5'd4, 32'd1, 3'd0, 32'd2, 3'd0, 3'd3);
    step();
    idle();
    flush = 1'b1;
    step();
    idle();
    checks++;
    if (issue_valid !== 1'b0 || issue_dest !== 3'd0) begin
      errors++;
      $display("FAIL flush_ready: v=%b d=%0d expected 0/0",
               issue_valid, issue_dest);
    end
    step();
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_after: got valid=%b expected 0", issue_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle();
    test_reset();
    test_ready_issue();
    test_alu_wakeup();
    test_dispatch_bypass();
    test_load_store_filter();
    test_fill_and_drain();
    test_back_to_back();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
